// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache port controller: turns one pipeline data request into a
// registered cache handshake, aligns byte data and stalls until completion.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    input  logic             mem_resp,
    input  logic [15:0]      mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [15:0]      mem_address,
    output logic [15:0]      mem_wdata,
    output logic [1:0]       mem_byte_enable,
    output logic             stall,
    output logic             done,
    output logic [15:0]      rdata,
    output logic             err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t           state_q;
    logic [TW-1:0]    tmo_q;
    logic             tmo_hit;
    logic             mem_read_q, mem_write_q;
    logic [15:0]      mem_address_q, mem_wdata_q, rdata_q;
    logic [1:0]       mem_byte_enable_q;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [15:0]      address_d, wdata_d, rdata_d;
    logic [1:0]       byte_enable_d;

    // Byte lane 1 (odd address) is the high half of the 16-bit word.
    function automatic logic [1:0] lane_enable(input logic is_byte, input logic odd);
        if (!is_byte) return 2'b11;
        return odd ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] align_rdata(input logic [15:0] d, input logic [1:0] be,
                                                input logic is_write);
        logic [7:0] b;
        b = (be == 2'b10) ? d[15:8] : d[7:0];
        if (is_write)     return 16'h0000;
        if (be == 2'b11)  return d;
        return {{8{b[7]}}, b};
    endfunction

    assign address_d     = req_byte ? req_addr : {req_addr[15:1], 1'b0};
    assign byte_enable_d = lane_enable(req_byte, req_addr[0]);
    assign wdata_d       = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
    assign rdata_d       = align_rdata(mem_rdata, mem_byte_enable_q, mem_write_q);

    assign tmo_hit = (TIMEOUT != 0) &&
                     (({1'b0, tmo_q} + (TW+1)'(1)) == (TW+1)'(TIMEOUT));

    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = req_valid;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            tmo_q             <= '0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_address_q     <= '0;
            mem_wdata_q       <= '0;
            mem_byte_enable_q <= '0;
            rdata_q           <= '0;
            err_q             <= 1'b0;
            stall_cnt_q       <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_address_q     <= address_d;
                        mem_wdata_q       <= wdata_d;
                        mem_byte_enable_q <= byte_enable_d;
                        mem_read_q        <= ~req_write;
                        mem_write_q       <= req_write;
                        tmo_q             <= '0;
                        state_q           <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rdata_q     <= rdata_d;
                        state_q     <= RESP;
                    end else if (tmo_hit) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                // The request is still presented here; it must not be re-issued.
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_byte_enable_q;
    assign done            = (state_q == RESP);
    assign rdata           = rdata_q;
    assign err             = err_q;
    assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          reset, req_valid, req_write, req_byte, mem_resp;
    logic [15:0]   req_addr, req_wdata, mem_rdata;
    logic          mem_read, mem_write, stall, done, err;
    logic [15:0]   mem_address, mem_wdata, rdata;
    logic [1:0]    mem_byte_enable;
    logic [CW-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;
    int sc_m  = 0;
    bit err_m = 0;

    mem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .stall(stall), .done(done), .rdata(rdata),
        .err(err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access; dly = BUSY cycle in which the cache answers.
    task automatic access(input bit wr, input bit by, input logic [15:0] addr,
                          input logic [15:0] wd, input int dly, input logic [15:0] mrd,
                          input bit spur);
        logic [15:0] e_addr, e_wd, e_rd, a;
        logic [7:0]  sel;
        logic [1:0]  e_be;
        int          nb, v;
        bit          tmo;
        a      = addr;
        e_addr = by ? a : (a & 16'hFFFE);
        e_be   = !by ? 2'b11 : ((a % 2) == 1 ? 2'b10 : 2'b01);
        e_wd   = by ? ((wd & 16'h00FF) * 16'd257) : wd;
        tmo    = (dly > TMO);
        nb     = tmo ? TMO : dly;
        if (wr || tmo) e_rd = 16'h0000;
        else if (!by) e_rd = mrd;
        else begin
            sel = ((a % 2) == 1) ? mrd[15:8] : mrd[7:0];
            v = int'(sel);
            if (v > 127) v = v - 256;
            e_rd = 16'(v);
        end

        req_valid = 1'b1; req_write = wr; req_byte = by; req_addr = addr; req_wdata = wd;
        mem_resp = 1'b0;
        #1;
        chk("stall_req", stall, 1);
        chk("done_req", done, 0);
        step();
        for (int n = 1; n <= nb; n++) begin
            if (n == nb && !tmo) begin mem_resp = 1'b1; mem_rdata = mrd; end
            else begin mem_resp = 1'b0; mem_rdata = 16'($urandom); end
            #1;
            chk("busy_read", mem_read, !wr);
            chk("busy_write", mem_write, wr);
            chk("busy_addr", mem_address, e_addr);
            chk("busy_be", mem_byte_enable, e_be);
            chk("busy_wdata", mem_wdata, e_wd);
            chk("busy_stall", stall, 1);
            chk("busy_done", done, 0);
            step();
            mem_resp = 1'b0;
        end
        sc_m = sc_m + 1 + nb;
        if (sc_m > 255) sc_m = 255;
        if (tmo) err_m = 1;
        mem_resp  = spur;
        mem_rdata = 16'($urandom);
        #1;
        chk("resp_done", done, 1);
        chk("resp_stall", stall, 0);
        chk("resp_rdata", rdata, e_rd);
        chk("resp_read", mem_read, 0);
        chk("resp_write", mem_write, 0);
        chk("resp_err", err, err_m);
        chk("stall_count", stall_count, sc_m);
        step();
        mem_resp = 1'b0;
    endtask

    task automatic idle(input int cycles);
        req_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            mem_resp = 1'($urandom);
            #1;
            chk("idle_stall", stall, 0);
            chk("idle_done", done, 0);
            step();
        end
        mem_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_read", mem_read, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_byte_enable, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        step();

        access(0, 0, 16'h1235, 16'h0000, 3, 16'hBEEF, 0);
        idle(1);
        access(0, 1, 16'h2001, 16'h0000, 2, 16'h80FF, 0);
        idle(1);
        access(0, 1, 16'h2000, 16'h0000, 1, 16'h80FF, 1);
        idle(2);
        access(1, 1, 16'h3003, 16'h12A5, 2, 16'hFFFF, 0);
        idle(1);
        access(0, 0, 16'h4000, 16'h0000, 2, 16'h5000, 0);
        access(0, 0, 16'h5000, 16'h0000, 2, 16'h0042, 0);
        idle(1);
        access(0, 0, 16'h6000, 16'h0000, TMO + 1, 16'h1111, 0);
        idle(1);

        for (int t = 0; t < 150; t++) begin
            access(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(1, 6)), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end

        // Abort an access mid-BUSY; its late response must not complete anything.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 16'h7777; req_wdata = 16'h0;
        step();
        #1;
        chk("abort_busy", mem_read, 1);
        reset = 1'b1;
        step();
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk("abort_read", mem_read, 0);
        chk("abort_addr", mem_address, 0);
        chk("abort_err", err, 0);
        chk("abort_cnt", stall_count, 0);
        chk("abort_stall", stall, 0);
        mem_resp = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_resp = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_rdata", rdata, 0);
        step();
        #1;
        chk("abort_done2", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
